// File: rtl/pipe_reg.sv
// Purpose : DEPTH-stage valid/ready register pipeline with bubble collapse and flush.
// Latency : DEPTH-1 edges from accept to out_valid (DEPTH=1: visible right after the accept edge).
// Backpressure: ready ripples combinationally from out_ready; an empty stage is always ready.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset (clears valids, loads RESET_VAL into data)
//   flush      synchronous discard of every held item; data registers keep their values
//   in_valid / in_ready / in_data     upstream handshake (stage 0)
//   out_valid / out_ready / out_data  downstream handshake (stage DEPTH-1)
//   occupancy  number of stages currently holding an item

module pipe_reg #(
    parameter int              WIDTH     = 32,
    parameter int              DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH+1);

    // Stage state: index 0 faces the input, DEPTH-1 faces the output.
    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];

    // Per-stage readiness and the value each stage would load from upstream.
    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] up_v;
    logic [WIDTH-1:0] up_d [DEPTH];

    // Ready chain, walked from the output side towards the input. A scalar
    // carries the running value so the vector is never read while it is built.
    always_comb begin
        logic r;
        rdy = '0;
        r   = !v[DEPTH-1] || out_ready;
        rdy[DEPTH-1] = r;
        for (int k = DEPTH-2; k >= 0; k--) begin
            r      = !v[k] || r;
            rdy[k] = r;
        end
    end

    always_comb begin
        up_v    = '0;
        up_v[0] = in_valid;
        up_d[0] = in_data;
        for (int k = 1; k < DEPTH; k++) begin
            up_v[k] = v[k-1];
            up_d[k] = d[k-1];
        end
    end

    // Stage 0 only differs from in_ready by flush/reset, both of which
    // override the shift below, so rdy[0] is safe to use directly there.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                d[k] <= RESET_VAL;
            end
        end else if (flush) begin
            // Valids drop, data is left alone so nothing but the valids toggles.
            v <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (rdy[k]) begin
                    v[k] <= up_v[k];
                    // Data only moves with a real item; bubbles leave it as is.
                    if (up_v[k]) begin
                        d[k] <= up_d[k];
                    end
                end
            end
        end
    end

    always_comb begin
        occupancy = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occupancy = occupancy + OCC_W'(v[k]);
        end
    end

    assign in_ready  = rdy[0] && !flush && reset;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

endmodule

// File: tb/tb_pipe_reg.sv
// Bench for pipe_reg: a DEPTH=4/WIDTH=32 instance driven from a vector table plus
// a reset sequence, and a DEPTH=1/WIDTH=8 instance under random backpressure
// checked against a queue model.

module tb_pipe_reg;

    localparam logic [31:0] RV4 = 32'hDEAD_BEEF;
    localparam logic [7:0]  RV1 = 8'h5A;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DEPTH=4 instance
    logic        fl4 = 1'b0, iv4 = 1'b0, or4 = 1'b0;
    logic [31:0] id4 = '0;
    logic        ir4, ov4;
    logic [31:0] od4;
    logic [2:0]  occ4;

    pipe_reg #(.WIDTH(32), .DEPTH(4), .RESET_VAL(RV4)) dut4 (
        .clk(clk), .reset(rst_n), .flush(fl4),
        .in_valid(iv4), .in_ready(ir4), .in_data(id4),
        .out_valid(ov4), .out_ready(or4), .out_data(od4),
        .occupancy(occ4)
    );

    // DEPTH=1 instance
    logic       fl1 = 1'b0, iv1 = 1'b0, or1 = 1'b0;
    logic [7:0] id1 = '0;
    logic       ir1, ov1;
    logic [7:0] od1;
    logic [0:0] occ1;

    pipe_reg #(.WIDTH(8), .DEPTH(1), .RESET_VAL(RV1)) dut1 (
        .clk(clk), .reset(rst_n), .flush(fl1),
        .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1),
        .occupancy(occ1)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs applied before an edge; exp_ir is checked before that edge,
    // the rest right after it.
    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        exp_ir;
        logic        exp_ov;
        logic [31:0] exp_od;
        int          exp_occ;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // streaming, out_ready=1: 11,22,33 appear 3 edges after accept
        tbl.push_back('{1'b0, 1'b1, 32'h11, 1'b1, 1'b1, 1'b0, RV4,   1});
        tbl.push_back('{1'b0, 1'b1, 32'h22, 1'b1, 1'b1, 1'b0, RV4,   2});
        tbl.push_back('{1'b0, 1'b1, 32'h33, 1'b1, 1'b1, 1'b0, RV4,   3});
        tbl.push_back('{1'b0, 1'b0, 32'hFF, 1'b1, 1'b1, 1'b1, 32'h11, 3});
        tbl.push_back('{1'b0, 1'b0, 32'hFF, 1'b1, 1'b1, 1'b1, 32'h22, 2});
        tbl.push_back('{1'b0, 1'b0, 32'hFF, 1'b1, 1'b1, 1'b1, 32'h33, 1});
        tbl.push_back('{1'b0, 1'b0, 32'hFF, 1'b1, 1'b1, 1'b0, 32'h33, 0});
        // fill with out_ready=0: 4 accepted, 5th refused
        tbl.push_back('{1'b0, 1'b1, 32'hA1, 1'b0, 1'b1, 1'b0, 32'h33, 1});
        tbl.push_back('{1'b0, 1'b1, 32'hA2, 1'b0, 1'b1, 1'b0, 32'h33, 2});
        tbl.push_back('{1'b0, 1'b1, 32'hA3, 1'b0, 1'b1, 1'b0, 32'h33, 3});
        tbl.push_back('{1'b0, 1'b1, 32'hA4, 1'b0, 1'b1, 1'b1, 32'hA1, 4});
        tbl.push_back('{1'b0, 1'b1, 32'hA5, 1'b0, 1'b0, 1'b1, 32'hA1, 4});
        // full with out_ready=1: accept+emit on same edge, occupancy stays 4
        tbl.push_back('{1'b0, 1'b1, 32'hA5, 1'b1, 1'b1, 1'b1, 32'hA2, 4});
        tbl.push_back('{1'b0, 1'b1, 32'hA6, 1'b1, 1'b1, 1'b1, 32'hA3, 4});
        tbl.push_back('{1'b0, 1'b1, 32'hA7, 1'b1, 1'b1, 1'b1, 32'hA4, 4});
        tbl.push_back('{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'hA5, 3});
        tbl.push_back('{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'hA6, 2});
        tbl.push_back('{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'hA7, 1});
        tbl.push_back('{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 32'hA7, 0});
        // gap between B0 and C0 with out_ready=0: bubble collapses
        tbl.push_back('{1'b0, 1'b1, 32'hB0, 1'b0, 1'b1, 1'b0, 32'hA7, 1});
        tbl.push_back('{1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 32'hA7, 1});
        tbl.push_back('{1'b0, 1'b1, 32'hC0, 1'b0, 1'b1, 1'b0, 32'hA7, 2});
        tbl.push_back('{1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 32'hB0, 2});
        tbl.push_back('{1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 32'hB0, 2});
        // C0 now sits directly behind B0: it follows on the very next edge
        tbl.push_back('{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'hC0, 1});
        // load to 3 items, then flush with in_valid=1
        tbl.push_back('{1'b0, 1'b1, 32'hD1, 1'b0, 1'b1, 1'b1, 32'hC0, 2});
        tbl.push_back('{1'b0, 1'b1, 32'hD2, 1'b0, 1'b1, 1'b1, 32'hC0, 3});
        tbl.push_back('{1'b1, 1'b1, 32'hD3, 1'b1, 1'b0, 1'b0, 32'hC0, 0});
        tbl.push_back('{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 32'hC0, 0});
        // fill to full ahead of the reset sequence
        tbl.push_back('{1'b0, 1'b1, 32'hE1, 1'b0, 1'b1, 1'b0, 32'hC0, 1});
        tbl.push_back('{1'b0, 1'b1, 32'hE2, 1'b0, 1'b1, 1'b0, 32'hC0, 2});
        tbl.push_back('{1'b0, 1'b1, 32'hE3, 1'b0, 1'b1, 1'b0, 32'hC0, 3});
        tbl.push_back('{1'b0, 1'b1, 32'hE4, 1'b0, 1'b1, 1'b1, 32'hE1, 4});
    end

    initial begin
        byte unsigned q[$];
        int sent, recv;
        logic emit, acc;

        // reset state
        #12;
        check("rst4_ov",  32'(ov4),  32'd0);
        check("rst4_od",  od4,       RV4);
        check("rst4_occ", 32'(occ4), 32'd0);
        check("rst4_ir",  32'(ir4),  32'd0);
        check("rst1_ov",  32'(ov1),  32'd0);
        check("rst1_od",  32'(od1),  32'(RV1));
        @(negedge clk);
        rst_n = 1'b1;

        // table-driven section
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            fl4 = tbl[i].fl;
            iv4 = tbl[i].iv;
            id4 = tbl[i].id;
            or4 = tbl[i].ordy;
            #1;
            check($sformatf("v%0d_in_ready", i), 32'(ir4), 32'(tbl[i].exp_ir));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_out_valid", i), 32'(ov4), 32'(tbl[i].exp_ov));
            check($sformatf("v%0d_out_data", i), od4, tbl[i].exp_od);
            check($sformatf("v%0d_occupancy", i), 32'(occ4), 32'(tbl[i].exp_occ));
        end

        // asynchronous reset while full, checked before the next edge
        @(negedge clk);
        fl4 = 1'b0; iv4 = 1'b0; or4 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_ov",  32'(ov4),  32'd0);
        check("arst_od",  od4,       RV4);
        check("arst_occ", 32'(occ4), 32'd0);
        check("arst_ir",  32'(ir4),  32'd0);

        // first edge after release accepts; item appears DEPTH-1 edges later
        @(negedge clk);
        rst_n = 1'b1;
        iv4 = 1'b1; id4 = 32'hF1; or4 = 1'b1;
        #1;
        check("post_rst_ir", 32'(ir4), 32'd1);
        @(posedge clk);
        #1;
        check("post_rst_occ", 32'(occ4), 32'd1);
        check("post_rst_ov0", 32'(ov4),  32'd0);
        @(negedge clk);
        iv4 = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk);
            #1;
            if (e < 3) begin
                check($sformatf("post_rst_ov_e%0d", e), 32'(ov4), 32'd0);
            end else begin
                check("post_rst_ov_e3", 32'(ov4), 32'd1);
                check("post_rst_od_e3", od4,      32'hF1);
            end
        end
        @(posedge clk);
        #1;
        check("post_rst_drain", 32'(occ4), 32'd0);

        // DEPTH=1 under random backpressure, checked against a queue model
        sent = 0;
        recv = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            iv1 = 1'($urandom_range(0, 1));
            or1 = 1'($urandom_range(0, 1));
            id1 = 8'(sent + 1);
            #1;
            check("d1_in_ready", 32'(ir1), 32'(!ov1 || or1));
            check("d1_occ", 32'(occ1), 32'(ov1));
            emit = ov1 && or1;
            acc  = iv1 && ir1;
            if (emit) begin
                if (q.size() == 0) begin
                    check("d1_spurious_emit", 32'(od1), 32'hFFFF_FFFF);
                end else begin
                    check("d1_order", 32'(od1), 32'(q.pop_front()));
                    recv++;
                end
            end
            if (acc) begin
                q.push_back(id1);
                sent++;
            end
            @(posedge clk);
        end
        @(negedge clk);
        iv1 = 1'b0;
        or1 = 1'b1;
        for (int c = 0; c < 4 && q.size() > 0; c++) begin
            #1;
            if (ov1) begin
                check("d1_drain_order", 32'(od1), 32'(q.pop_front()));
                recv++;
            end
            @(negedge clk);
        end
        check("d1_all_emitted", 32'(recv), 32'(sent));
        check("d1_queue_empty", 32'(q.size()), 32'd0);
        check("d1_some_traffic", 32'(sent > 50), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_reg.md
PIPE_REG -- requirements
Module: pipe_reg

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, meaning the data bits per stage (legal range 1 or more).
REQ-002 The module SHALL have parameter DEPTH, default 4, meaning the number of pipeline stages (legal range 1 or more).
REQ-003 The module SHALL have parameter RESET_VAL, default 0 (WIDTH bits), meaning the data value loaded into every stage on reset.
REQ-004 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-005 Port list SHALL be:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-low reset
- flush  input  1  synchronous discard of all held items
- in_valid  input  1  upstream item present
- in_ready  output  1  pipe can accept this cycle
- in_data  input  WIDTH  upstream item
- out_valid  output  1  stage DEPTH-1 holds an item
- out_ready  input  1  downstream accepts this cycle
- out_data  output  WIDTH  stage DEPTH-1 data
- occupancy  output  clog2(DEPTH+1)  count of valid stages

Function
REQ-006 Each stage k (0..DEPTH-1) SHALL hold a valid bit v[k] and a data word d[k]; stage 0 is the input side and stage DEPTH-1 is the output side.
REQ-007 out_valid SHALL equal v[DEPTH-1], and out_data SHALL equal d[DEPTH-1].
REQ-008 Stage readiness SHALL be combinational: rdy[DEPTH-1] = !v[DEPTH-1] or out_ready; rdy[k] = !v[k] or rdy[k+1].
REQ-009 in_ready SHALL equal rdy[0] and flush inactive and reset deasserted.
REQ-010 On a rising edge with rdy[k]=1, v[k] SHALL load the upstream valid (in_valid for k=0, v[k-1] otherwise); with rdy[k]=0, stage k SHALL hold.
REQ-011 d[k] SHALL load upstream data only when rdy[k]=1 and the upstream valid is 1; otherwise d[k] SHALL hold.
REQ-012 An item is accepted on an edge where in_valid=1 and in_ready=1; in_data SHALL be ignored whenever in_valid=0.
REQ-013 An item is emitted on an edge where out_valid=1 and out_ready=1.
REQ-014 Latency: an item accepted at edge n with no stalls SHALL appear at the output after edge n+DEPTH-1. For DEPTH=1, it SHALL appear directly after the accept edge.
REQ-015 Throughput: with out_ready held at 1, the block SHALL accept and emit one item per cycle with no bubbles inserted.
REQ-016 Bubbles SHALL collapse: with out_ready=0, a new item SHALL advance into the furthest empty stage reachable through the ready chain, one stage per cycle.
REQ-017 Full condition (all v=1), out_ready=0: in_ready SHALL be 0 and all stages SHALL hold.
REQ-018 Full condition, out_ready=1, in_valid=1: accept and emit SHALL occur on the same edge, and occupancy SHALL stay at DEPTH.
REQ-019 Empty condition: out_valid SHALL be 0, occupancy SHALL be 0, and in_ready SHALL be 1.
REQ-020 flush=1 at an edge SHALL clear all v[k] to 0, discard the input (in_ready=0), and emit nothing; d[k] SHALL be unchanged. Flush SHALL take priority over out_ready and in_valid.
REQ-021 occupancy SHALL be the combinational population count of v[0..DEPTH-1].
REQ-022 Item order SHALL be strictly preserved, with no duplication or loss except by flush or reset.

Reset
REQ-023 While reset=0, regardless of clk: all v[k]=0, all d[k]=RESET_VAL, out_valid=0, out_data=RESET_VAL, occupancy=0, in_ready=0.
REQ-024 Reset asserted mid-operation SHALL discard all in-flight items immediately.
REQ-025 After reset deasserts, the first rising edge SHALL be able to accept an item.

Verification
REQ-026 WIDTH=32, DEPTH=4, out_ready=1: drive 0x11,0x22,0x33 on consecutive cycles. Required: out_data shows 0x11,0x22,0x33 on consecutive cycles, starting 3 edges after the first accept.
REQ-027 DEPTH=4, out_ready=0: offer 5 items. Required: 4 accepted, in_ready=0 afterward, occupancy=4; then set out_ready=1 and drive in_valid=1. Required: one emit and one accept per cycle, with occupancy staying at 4.
REQ-028 DEPTH=4: insert a gap between items A and B, with out_ready=0. Required: A and B end in stages 3 and 2, with occupancy=2 and no bubble between them.
REQ-029 Pipe holding 3 items: pulse flush with in_valid=1. Required: next cycle out_valid=0, occupancy=0, and the offered item is not accepted.
REQ-030 Pull reset low asynchronously mid-stream with pipe full. Required: out_valid=0 and out_data=RESET_VAL before the next edge; first post-release item has DEPTH-1 edge latency.
REQ-031 DEPTH=1, WIDTH=8: toggle out_ready randomly. Required: in_ready = !out_valid or out_ready, and every input byte is emitted exactly once in order.
